// File: rtl/leaf_out_arbiter_if.sv
// Requester-side and leaf-side stream signals of leaf_out_arbiter, bundled as one bus.
// master is the arbiter's view; slave is the view of the surrounding leaf logic.
interface leaf_out_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_PORT_BITS = 4
);
    logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user;
    logic [NUM_REQ-1:0]              vld_user;
    logic [NUM_REQ-1:0]              ack_to_user;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic [NUM_PORT_BITS-1:0]        dout_src;
    logic                            vld_out;
    logic                            ack_in;

    modport master (
        input  din_user,
        input  vld_user,
        input  ack_in,
        output ack_to_user,
        output dout,
        output dout_src,
        output vld_out
    );

    modport slave (
        output din_user,
        output vld_user,
        output ack_in,
        input  ack_to_user,
        input  dout,
        input  dout_src,
        input  vld_out
    );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-locking arbiter sharing one leaf_interface output stream among
// NUM_REQ operator streams, with a one-entry registered output buffer.
module leaf_out_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_PORT_BITS = 4,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned IDLE_TIMEOUT  = 4
) (
    input  logic               clk_user,
    input  logic               reset,
    leaf_out_arbiter_if.master bus,
    output logic               busy
);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned SUM_W  = NUM_PORT_BITS + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]               state, state_n;
    logic [NUM_PORT_BITS-1:0] sel, sel_n;
    logic [NUM_PORT_BITS-1:0] rr_ptr, rr_n;
    logic [BEAT_W-1:0]        beat_cnt, beat_n;
    logic [IDLE_W-1:0]        idle_cnt, idle_n;

    logic                     obuf_full;
    logic [PAYLOAD_BITS-1:0]  obuf_data;
    logic [NUM_PORT_BITS-1:0] obuf_src;

    logic                     sel_vld;
    logic [PAYLOAD_BITS-1:0]  sel_data;
    logic                     can_load;
    logic                     xfer;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_PORT_BITS-1:0] sel_inc;
    logic [BEAT_W-1:0]        beat_inc;
    logic [IDLE_W-1:0]        idle_inc;
    logic                     burst_done;
    logic                     timed_out;

    logic [2*NUM_REQ-1:0]     vld_dbl;
    logic [NUM_REQ-1:0]       vld_rot;
    logic                     any_vld;
    logic [NUM_PORT_BITS-1:0] pick_ofs;
    logic [SUM_W-1:0]         pick_sum;
    logic [NUM_PORT_BITS-1:0] pick;

    // Selected requester's valid and data.
    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (sel == NUM_PORT_BITS'(j)) begin
                sel_vld  = bus.vld_user[j];
                sel_data = bus.din_user[j*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign can_load = !obuf_full || bus.ack_in;
    assign xfer     = (state != ST_IDLE) && sel_vld && can_load;

    always_comb begin
        ack = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            ack[j] = (state != ST_IDLE) && (sel == NUM_PORT_BITS'(j)) && can_load;
        end
    end

    assign bus.ack_to_user = ack;
    assign bus.vld_out     = obuf_full;
    assign bus.dout        = obuf_data;
    assign bus.dout_src    = obuf_src;
    assign busy            = (state != ST_IDLE) || obuf_full;

    assign sel_inc    = (sel == NUM_PORT_BITS'(NUM_REQ - 1)) ? '0 : sel + NUM_PORT_BITS'(1);
    assign beat_inc   = beat_cnt + BEAT_W'(1);
    assign idle_inc   = idle_cnt + IDLE_W'(1);
    assign burst_done = (beat_inc == BEAT_W'(BURST_LEN));
    assign timed_out  = (idle_inc == IDLE_W'(IDLE_TIMEOUT));

    // Rotate the valid vector so bit 0 is rr_ptr, take the first set bit, then
    // map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        vld_dbl  = {bus.vld_user, bus.vld_user};
        vld_rot  = NUM_REQ'(vld_dbl >> rr_ptr);
        any_vld  = 1'b0;
        pick_ofs = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_vld && vld_rot[k]) begin
                any_vld  = 1'b1;
                pick_ofs = NUM_PORT_BITS'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr} + SUM_W'(pick_ofs);
        if (pick_sum >= SUM_W'(NUM_REQ)) begin
            pick_sum = pick_sum - SUM_W'(NUM_REQ);
        end
        pick = pick_sum[NUM_PORT_BITS-1:0];
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        rr_n    = rr_ptr;
        beat_n  = beat_cnt;
        idle_n  = idle_cnt;
        case (state)
            ST_IDLE: begin
                if (any_vld) begin
                    state_n = ST_GRANT;
                    sel_n   = pick;
                    beat_n  = '0;
                    idle_n  = '0;
                end
            end
            ST_GRANT, ST_HOLD: begin
                if (xfer) begin
                    beat_n = beat_inc;
                    idle_n = '0;
                    if (burst_done) begin
                        state_n = ST_IDLE;
                        rr_n    = sel_inc;
                    end else begin
                        state_n = ST_GRANT;
                    end
                end else if (sel_vld) begin
                    // Backpressure, or HOLD re-entry while the buffer cannot load.
                    state_n = ST_GRANT;
                    idle_n  = '0;
                end else begin
                    // idle_cnt is 0 throughout GRANT, so the first stall yields 1 here.
                    if (timed_out) begin
                        state_n = ST_IDLE;
                        rr_n    = sel_inc;
                        idle_n  = '0;
                    end else begin
                        state_n = ST_HOLD;
                        idle_n  = idle_inc;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_user) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            rr_ptr   <= rr_n;
            beat_cnt <= beat_n;
            idle_cnt <= idle_n;
        end
    end

    // Load has priority over drain so a full buffer can turn over every cycle.
    always_ff @(posedge clk_user) begin
        if (!reset) begin
            obuf_full <= 1'b0;
            obuf_data <= '0;
            obuf_src  <= '0;
        end else if (xfer) begin
            obuf_full <= 1'b1;
            obuf_data <= sel_data;
            obuf_src  <= sel;
        end else if (bus.ack_in) begin
            obuf_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: cycle-by-cycle expected acks per scenario,
// with a one-entry output buffer model for dout/dout_src/vld_out.
module tb_leaf_out_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wd [4];
    int          remain [4];
    logic        ob_full;
    logic [31:0] ob_data;
    logic [3:0]  ob_src;

    leaf_out_arbiter_if #(.NUM_REQ(4), .PAYLOAD_BITS(32), .NUM_PORT_BITS(4)) bus ();

    leaf_out_arbiter #(
        .NUM_REQ      (4),
        .PAYLOAD_BITS (32),
        .NUM_PORT_BITS(4),
        .BURST_LEN    (8),
        .IDLE_TIMEOUT (4)
    ) dut (
        .clk_user(clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) bus.din_user[i*32 +: 32] = wd[i];
    endtask

    // One cycle: check outputs against the hand-computed ack and the buffer model,
    // then advance the source and buffer model across the clock edge.
    task automatic cyc(input string tag, input logic [3:0] exp_ack);
        logic [3:0] xf;
        #1;
        chk({tag, "_ack"}, 32'(bus.ack_to_user), 32'(exp_ack));
        chk({tag, "_vld"}, 32'(bus.vld_out), 32'(ob_full));
        chk({tag, "_busy"}, 32'(busy), 32'((exp_ack != 4'd0) || ob_full));
        if (ob_full) begin
            chk({tag, "_dout"}, bus.dout, ob_data);
            chk({tag, "_src"}, 32'(bus.dout_src), 32'(ob_src));
        end
        xf = exp_ack & bus.vld_user;
        tick();
        if (xf != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (xf[i]) begin
                    ob_data = wd[i];
                    ob_src  = i[3:0];
                    wd[i]   = wd[i] + 32'd1;
                    remain[i]--;
                    if (remain[i] == 0) bus.vld_user[i] = 1'b0;
                end
            end
            ob_full = 1'b1;
        end else if (bus.ack_in) begin
            ob_full = 1'b0;
        end
        drive();
    endtask

    task automatic restart();
        reset        = 1'b0;
        bus.vld_user = '0;
        bus.ack_in   = 1'b1;
        tick();
        reset   = 1'b1;
        ob_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wd[i]     = 32'(i) << 12;
            remain[i] = 1000;
        end
        drive();
    endtask

    initial begin
        // Reset held with all requesters valid.
        reset        = 1'b0;
        bus.ack_in   = 1'b1;
        bus.vld_user = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wd[i]     = 32'hA0 + 32'(i);
            remain[i] = 1000;
        end
        drive();
        ob_full = 1'b0;
        ob_data = '0;
        ob_src  = '0;
        repeat (3) tick();
        chk("rst_vld_out", 32'(bus.vld_out), 32'd0);
        chk("rst_ack", 32'(bus.ack_to_user), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_src", 32'(bus.dout_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        cyc("rst_c0", 4'b0000);
        cyc("rst_c1", 4'b0001);
        cyc("rst_c2", 4'b0001);

        // Single requester 2, 20 words: bursts 8,8,4 with a dead cycle between.
        restart();
        wd[2]        = 32'h100;
        remain[2]    = 20;
        bus.vld_user = 4'b0100;
        drive();
        for (int c = 0; c < 23; c++) cyc("single", (c % 9 != 0) ? 4'b0100 : 4'b0000);
        cyc("single_end", 4'b0100);

        // All four requesting: grant order 0,1,2,3,0, eight words each.
        restart();
        bus.vld_user = 4'b1111;
        for (int c = 0; c < 41; c++)
            cyc("rr", (c % 9 == 0) ? 4'b0000 : 4'(1 << ((c / 9) % 4)));

        // Backpressure: ack_in low for 5 cycles mid-burst does not count as a stall.
        restart();
        bus.vld_user = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            bus.ack_in = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
            cyc("bp", (c == 0 || (c >= 4 && c <= 8) || c == 14) ? 4'b0000 : 4'b0001);
        end
        bus.ack_in = 1'b1;

        // Stall timeout: req 1 sends 3 words, stalls 4 cycles, grant moves to req 2.
        restart();
        remain[1]    = 3;
        bus.vld_user = 4'b0110;
        for (int c = 0; c < 12; c++)
            cyc("tmo", (c == 0 || c == 8) ? 4'b0000 : (c < 8 ? 4'b0010 : 4'b0100));

        // Req 1 reasserts on stall cycle 3 and finishes the same 8-word burst.
        restart();
        remain[1]    = 3;
        bus.vld_user = 4'b0110;
        for (int c = 0; c < 6; c++) cyc("resume", (c == 0) ? 4'b0000 : 4'b0010);
        bus.vld_user[1] = 1'b1;
        remain[1]       = 1000;
        for (int c = 6; c < 14; c++)
            cyc("resume", (c == 11) ? 4'b0000 : (c < 11 ? 4'b0010 : 4'b0100));

        // Reset during req 1's burst: buffer discarded, arbitration restarts at 0.
        restart();
        bus.vld_user = 4'b1111;
        for (int c = 0; c < 12; c++)
            cyc("mid", (c == 0) ? 4'b0000 : (c < 9 ? 4'b0001 : (c == 9 ? 4'b0000 : 4'b0010)));
        reset = 1'b0;
        #1;
        chk("mid_pre_vld", 32'(bus.vld_out), 32'(ob_full));
        chk("mid_pre_dout", bus.dout, ob_data);
        tick();
        chk("mid_rst_vld", 32'(bus.vld_out), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack_to_user), 32'd0);
        chk("mid_rst_dout", bus.dout, 32'd0);
        chk("mid_rst_src", 32'(bus.dout_src), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset   = 1'b1;
        ob_full = 1'b0;
        cyc("mid_post", 4'b0000);
        cyc("mid_post", 4'b0001);
        cyc("mid_post", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
